// File: rtl/core_pkg.sv
// Shared types and constants for the RV32I core back end.
package core_pkg;

   // Kind of result offered to the writeback stage.
   typedef enum logic [1:0] {
      NONE = 2'd0,
      ALU  = 2'd1,
      LOAD = 2'd2,
      RSVD = 2'd3
   } wb_kind_t;

   // Writeback stage control states.
   typedef enum logic {
      IDLE      = 1'b0,
      LOAD_WAIT = 1'b1
   } wb_state_t;

   // Load size/sign encodings (funct3).
   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;

endpackage

// File: rtl/load_align.sv
// Extracts and sign/zero-extends load data from an aligned 32-bit read word.
module load_align
   import core_pkg::*;
(
   input  logic [31:0] rdata,
   input  logic [1:0]  off,
   input  logic [2:0]  funct3,
   output logic [31:0] value,
   output logic        illegal
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   // Select the addressed byte/halfword, then extend according to funct3.
   always_comb begin
      byte_sel = rdata[7:0];
      case (off)
         2'd0: byte_sel = rdata[7:0];
         2'd1: byte_sel = rdata[15:8];
         2'd2: byte_sel = rdata[23:16];
         2'd3: byte_sel = rdata[31:24];
         default: byte_sel = rdata[7:0];
      endcase
      half_sel = off[1] ? rdata[31:16] : rdata[15:0];

      value   = '0;
      illegal = 1'b0;
      case (funct3)
         F3_LB:  value = {{24{byte_sel[7]}}, byte_sel};
         F3_LH:  value = {{16{half_sel[15]}}, half_sel};
         F3_LW:  value = rdata;
         F3_LBU: value = {24'd0, byte_sel};
         F3_LHU: value = {16'd0, half_sel};
         default: illegal = 1'b1;
      endcase
   end

endmodule

// File: rtl/writeback_stage.sv
// Final pipeline stage: commits ALU results and completed loads to the register file.
module writeback_stage
   import core_pkg::*;
#(
   parameter int XLEN         = 32,
   parameter int LOAD_TIMEOUT = 255
)(
   input  logic            clk,
   input  logic            rst_n,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [1:0]      in_kind,
   input  logic [4:0]      in_rd_addr,
   input  logic [XLEN-1:0] in_result,
   input  logic [2:0]      in_funct3,
   input  logic            dmem_rsp_valid,
   input  logic [XLEN-1:0] dmem_rsp_rdata,
   input  logic            dmem_rsp_err,
   output logic [4:0]      rd_addr,
   output logic [XLEN-1:0] rd_data,
   output logic            rd_write_enable,
   output logic            retire,
   output logic            load_fault,
   output logic [XLEN-1:0] fault_addr,
   output logic            busy
);

   localparam logic [15:0] TMO_COUNT = 16'(LOAD_TIMEOUT);

   wb_state_t       state_q, state_d;
   wb_kind_t        kind;
   logic            run_q;
   logic [15:0]     cnt_q, cnt_d, cnt_inc;
   logic [4:0]      ld_rd_q, ld_rd_d;
   logic [2:0]      ld_f3_q, ld_f3_d;
   logic [XLEN-1:0] ld_addr_q, ld_addr_d;
   logic [XLEN-1:0] ld_value;
   logic            ld_illegal;

   logic [4:0]      rd_addr_d;
   logic [XLEN-1:0] rd_data_d, fault_addr_d;
   logic            we_d, retire_d, fault_d, busy_d;

   assign kind    = wb_kind_t'(in_kind);
   assign cnt_inc = cnt_q + 16'd1;

   // run_q keeps in_ready low until the first clock after reset release.
   assign in_ready = run_q && (state_q == IDLE);

   load_align u_align (
      .rdata   (dmem_rsp_rdata),
      .off     (ld_addr_q[1:0]),
      .funct3  (ld_f3_q),
      .value   (ld_value),
      .illegal (ld_illegal)
   );

   // Next-state, load latch and registered-output computation.
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      ld_rd_d      = ld_rd_q;
      ld_f3_d      = ld_f3_q;
      ld_addr_d    = ld_addr_q;
      rd_addr_d    = rd_addr;
      rd_data_d    = rd_data;
      fault_addr_d = fault_addr;
      we_d         = 1'b0;
      retire_d     = 1'b0;
      fault_d      = 1'b0;

      case (state_q)
         IDLE: begin
            if (in_valid && in_ready) begin
               case (kind)
                  ALU: begin
                     retire_d = 1'b1;
                     if (in_rd_addr != 5'd0) begin
                        we_d      = 1'b1;
                        rd_addr_d = in_rd_addr;
                        rd_data_d = in_result;
                     end
                  end
                  LOAD: begin
                     state_d   = LOAD_WAIT;
                     cnt_d     = '0;
                     ld_rd_d   = in_rd_addr;
                     ld_f3_d   = in_funct3;
                     ld_addr_d = in_result;
                  end
                  default: retire_d = 1'b1;
               endcase
            end
         end
         LOAD_WAIT: begin
            // A response in the timeout cycle takes priority over the timeout.
            if (dmem_rsp_valid) begin
               state_d = IDLE;
               if (dmem_rsp_err || ld_illegal) begin
                  fault_d      = 1'b1;
                  fault_addr_d = ld_addr_q;
               end else begin
                  retire_d = 1'b1;
                  if (ld_rd_q != 5'd0) begin
                     we_d      = 1'b1;
                     rd_addr_d = ld_rd_q;
                     rd_data_d = ld_value;
                  end
               end
            end else begin
               cnt_d = cnt_inc;
               if (cnt_inc == TMO_COUNT) begin
                  state_d      = IDLE;
                  fault_d      = 1'b1;
                  fault_addr_d = ld_addr_q;
               end
            end
         end
         default: state_d = IDLE;
      endcase

      busy_d = (state_d == LOAD_WAIT);
   end

   // Control state, timeout counter and latched load information.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         run_q     <= 1'b0;
         cnt_q     <= '0;
         ld_rd_q   <= '0;
         ld_f3_q   <= '0;
         ld_addr_q <= '0;
      end else begin
         state_q   <= state_d;
         run_q     <= 1'b1;
         cnt_q     <= cnt_d;
         ld_rd_q   <= ld_rd_d;
         ld_f3_q   <= ld_f3_d;
         ld_addr_q <= ld_addr_d;
      end
   end

   // Registered register-file write port and status outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_addr         <= '0;
         rd_data         <= '0;
         rd_write_enable <= 1'b0;
         retire          <= 1'b0;
         load_fault      <= 1'b0;
         fault_addr      <= '0;
         busy            <= 1'b0;
      end else begin
         rd_addr         <= rd_addr_d;
         rd_data         <= rd_data_d;
         rd_write_enable <= we_d;
         retire          <= retire_d;
         load_fault      <= fault_d;
         fault_addr      <= fault_addr_d;
         busy            <= busy_d;
      end
   end

endmodule

// File: tb/tb_writeback_stage.sv
// Directed self-checking bench for writeback_stage (LOAD_TIMEOUT = 8).
module tb_writeback_stage;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [1:0]  in_kind;
   logic [4:0]  in_rd_addr;
   logic [31:0] in_result;
   logic [2:0]  in_funct3;
   logic        dmem_rsp_valid;
   logic [31:0] dmem_rsp_rdata;
   logic        dmem_rsp_err;
   logic [4:0]  rd_addr;
   logic [31:0] rd_data;
   logic        rd_write_enable;
   logic        retire;
   logic        load_fault;
   logic [31:0] fault_addr;
   logic        busy;

   int n_cmp = 0;
   int n_bad = 0;

   writeback_stage #(.XLEN(32), .LOAD_TIMEOUT(8)) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .in_valid        (in_valid),
      .in_ready        (in_ready),
      .in_kind         (in_kind),
      .in_rd_addr      (in_rd_addr),
      .in_result       (in_result),
      .in_funct3       (in_funct3),
      .dmem_rsp_valid  (dmem_rsp_valid),
      .dmem_rsp_rdata  (dmem_rsp_rdata),
      .dmem_rsp_err    (dmem_rsp_err),
      .rd_addr         (rd_addr),
      .rd_data         (rd_data),
      .rd_write_enable (rd_write_enable),
      .retire          (retire),
      .load_fault      (load_fault),
      .fault_addr      (fault_addr),
      .busy            (busy)
   );

   always #5 clk = ~clk;

   // Advance one clock; outputs are sampled 1 time unit after the edge.
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic issue_load(input logic [4:0] rd, input logic [31:0] addr, input logic [2:0] f3);
      in_valid = 1'b1; in_kind = 2'd2; in_rd_addr = rd; in_result = addr; in_funct3 = f3;
      cyc();
      in_valid = 1'b0; in_kind = 2'd0;
   endtask

   task automatic respond(input logic [31:0] data, input logic err);
      dmem_rsp_valid = 1'b1; dmem_rsp_rdata = data; dmem_rsp_err = err;
      cyc();
      dmem_rsp_valid = 1'b0; dmem_rsp_err = 1'b0;
   endtask

   task automatic test_reset();
      n_cmp++; if ({rd_write_enable, retire, load_fault, busy, in_ready} !== 5'b0) begin n_bad++; $display("FAIL rst_ctl: got %b required 00000", {rd_write_enable, retire, load_fault, busy, in_ready}); end
      n_cmp++; if ({rd_addr, rd_data, fault_addr} !== 69'd0) begin n_bad++; $display("FAIL rst_data: got %h/%h/%h required 0", rd_addr, rd_data, fault_addr); end
      rst_n = 1'b1;
      #1;
      n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL rst_release_ready: got %b required 0", in_ready); end
      cyc();
      n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL ready_after_clk: got %b required 1", in_ready); end
   endtask

   task automatic test_alu_back_to_back();
      in_valid = 1'b1; in_kind = 2'd1; in_rd_addr = 5'd5; in_result = 32'h0000_1234;
      cyc();
      n_cmp++; if ({rd_write_enable, retire, rd_addr, rd_data} !== {1'b1, 1'b1, 5'd5, 32'h1234}) begin n_bad++; $display("FAIL alu0: got we=%b ret=%b rd=%0d data=%h required 1 1 5 00001234", rd_write_enable, retire, rd_addr, rd_data); end
      n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL alu0_ready: got %b required 1", in_ready); end
      in_rd_addr = 5'd6; in_result = 32'h0000_ABCD;
      cyc();
      n_cmp++; if ({rd_write_enable, retire, rd_addr, rd_data} !== {1'b1, 1'b1, 5'd6, 32'hABCD}) begin n_bad++; $display("FAIL alu1: got we=%b ret=%b rd=%0d data=%h required 1 1 6 0000abcd", rd_write_enable, retire, rd_addr, rd_data); end
      in_valid = 1'b0; in_kind = 2'd0;
      cyc();
      n_cmp++; if ({rd_write_enable, retire, rd_addr, rd_data} !== {1'b0, 1'b0, 5'd6, 32'hABCD}) begin n_bad++; $display("FAIL alu_hold: got we=%b ret=%b rd=%0d data=%h required 0 0 6 0000abcd", rd_write_enable, retire, rd_addr, rd_data); end
   endtask

   task automatic test_lb_sign();
      int busy_cycles = 0;
      issue_load(5'd7, 32'h0000_1003, 3'b000);
      n_cmp++; if ({in_ready, rd_write_enable, retire} !== 3'b000) begin n_bad++; $display("FAIL lb_accept: got ready/we/ret=%b required 000", {in_ready, rd_write_enable, retire}); end
      if (busy === 1'b1) busy_cycles++;
      for (int i = 0; i < 4; i++) begin
         cyc();
         if (busy === 1'b1) busy_cycles++;
         n_cmp++; if (rd_write_enable !== 1'b0) begin n_bad++; $display("FAIL lb_wait_we: cycle %0d got %b required 0", i, rd_write_enable); end
      end
      n_cmp++; if (busy_cycles != 5) begin n_bad++; $display("FAIL lb_busy_len: got %0d required 5", busy_cycles); end
      respond(32'h80FF_1234, 1'b0);
      n_cmp++; if ({rd_write_enable, retire, rd_addr, rd_data} !== {1'b1, 1'b1, 5'd7, 32'hFFFF_FF80}) begin n_bad++; $display("FAIL lb_commit: got we=%b ret=%b rd=%0d data=%h required 1 1 7 ffffff80", rd_write_enable, retire, rd_addr, rd_data); end
      n_cmp++; if ({busy, in_ready} !== 2'b01) begin n_bad++; $display("FAIL lb_idle: got busy/ready=%b required 01", {busy, in_ready}); end
      cyc();
      n_cmp++; if (rd_write_enable !== 1'b0) begin n_bad++; $display("FAIL lb_single_write: got %b required 0", rd_write_enable); end
      // Spurious response while idle.
      respond(32'h1111_2222, 1'b0);
      n_cmp++; if ({rd_write_enable, retire, load_fault, rd_data} !== {3'b000, 32'hFFFF_FF80}) begin n_bad++; $display("FAIL spurious: got we/ret/flt=%b data=%h required 000 ffffff80", {rd_write_enable, retire, load_fault}, rd_data); end
   endtask

   task automatic test_load_sizes();
      issue_load(5'd8, 32'h0000_2002, 3'b101);
      respond(32'h80FF_1234, 1'b0);
      n_cmp++; if ({rd_write_enable, rd_addr, rd_data} !== {1'b1, 5'd8, 32'h0000_80FF}) begin n_bad++; $display("FAIL lhu: got we=%b rd=%0d data=%h required 1 8 000080ff", rd_write_enable, rd_addr, rd_data); end
      issue_load(5'd9, 32'h0000_2002, 3'b001);
      respond(32'h80FF_1234, 1'b0);
      n_cmp++; if ({rd_write_enable, rd_addr, rd_data} !== {1'b1, 5'd9, 32'hFFFF_80FF}) begin n_bad++; $display("FAIL lh: got we=%b rd=%0d data=%h required 1 9 ffff80ff", rd_write_enable, rd_addr, rd_data); end
      issue_load(5'd10, 32'h0000_2002, 3'b100);
      respond(32'h80FF_1234, 1'b0);
      n_cmp++; if (rd_data !== 32'h0000_00FF) begin n_bad++; $display("FAIL lbu: got %h required 000000ff", rd_data); end
      issue_load(5'd11, 32'h0000_2003, 3'b010);
      respond(32'h80FF_1234, 1'b0);
      n_cmp++; if ({rd_addr, rd_data} !== {5'd11, 32'h80FF_1234}) begin n_bad++; $display("FAIL lw: got rd=%0d data=%h required 11 80ff1234", rd_addr, rd_data); end
   endtask

   task automatic test_bus_error();
      issue_load(5'd12, 32'h0000_3000, 3'b010);
      respond(32'hDEAD_BEEF, 1'b1);
      n_cmp++; if ({load_fault, rd_write_enable, retire, in_ready} !== 4'b1001) begin n_bad++; $display("FAIL err_pulse: got flt/we/ret/ready=%b required 1001", {load_fault, rd_write_enable, retire, in_ready}); end
      n_cmp++; if (fault_addr !== 32'h0000_3000) begin n_bad++; $display("FAIL err_addr: got %h required 00003000", fault_addr); end
      cyc();
      n_cmp++; if ({load_fault, fault_addr} !== {1'b0, 32'h0000_3000}) begin n_bad++; $display("FAIL err_hold: got flt=%b addr=%h required 0 00003000", load_fault, fault_addr); end
      issue_load(5'd13, 32'h0000_3100, 3'b011);
      respond(32'h1234_5678, 1'b0);
      n_cmp++; if ({load_fault, rd_write_enable, retire, fault_addr} !== {3'b100, 32'h0000_3100}) begin n_bad++; $display("FAIL illegal_f3: got flt/we/ret=%b addr=%h required 100 00003100", {load_fault, rd_write_enable, retire}, fault_addr); end
   endtask

   task automatic test_timeout();
      issue_load(5'd14, 32'h0000_4000, 3'b010);
      for (int i = 1; i < 8; i++) begin
         cyc();
         n_cmp++; if ({load_fault, busy} !== 2'b01) begin n_bad++; $display("FAIL tmo_wait: cycle %0d got flt/busy=%b required 01", i, {load_fault, busy}); end
      end
      cyc();
      n_cmp++; if ({load_fault, busy, in_ready, rd_write_enable, retire} !== 5'b10100) begin n_bad++; $display("FAIL tmo_fire: got flt/busy/ready/we/ret=%b required 10100", {load_fault, busy, in_ready, rd_write_enable, retire}); end
      n_cmp++; if (fault_addr !== 32'h0000_4000) begin n_bad++; $display("FAIL tmo_addr: got %h required 00004000", fault_addr); end
      respond(32'h5555_5555, 1'b0);
      n_cmp++; if ({rd_write_enable, retire, load_fault, rd_data} !== {3'b000, 32'h80FF_1234}) begin n_bad++; $display("FAIL tmo_late: got we/ret/flt=%b data=%h required 000 80ff1234", {rd_write_enable, retire, load_fault}, rd_data); end
      // Response in the very cycle the timeout would fire.
      issue_load(5'd15, 32'h0000_4100, 3'b010);
      repeat (7) cyc();
      respond(32'h0BAD_F00D, 1'b0);
      n_cmp++; if ({rd_write_enable, load_fault, rd_addr, rd_data} !== {2'b10, 5'd15, 32'h0BAD_F00D}) begin n_bad++; $display("FAIL tmo_race: got we=%b flt=%b rd=%0d data=%h required 1 0 15 0badf00d", rd_write_enable, load_fault, rd_addr, rd_data); end
   endtask

   task automatic test_rd_zero_and_none();
      in_valid = 1'b1; in_kind = 2'd1; in_rd_addr = 5'd0; in_result = 32'h0000_DEAD;
      cyc();
      n_cmp++; if ({retire, rd_write_enable, rd_data} !== {2'b10, 32'h0BAD_F00D}) begin n_bad++; $display("FAIL rd0: got ret/we=%b data=%h required 10 0badf00d", {retire, rd_write_enable}, rd_data); end
      in_kind = 2'd0; in_rd_addr = 5'd3;
      cyc();
      n_cmp++; if ({retire, rd_write_enable} !== 2'b10) begin n_bad++; $display("FAIL kind_none: got ret/we=%b required 10", {retire, rd_write_enable}); end
      in_kind = 2'd3;
      cyc();
      n_cmp++; if ({retire, rd_write_enable, busy} !== 3'b100) begin n_bad++; $display("FAIL kind_rsvd: got ret/we/busy=%b required 100", {retire, rd_write_enable, busy}); end
      in_valid = 1'b0; in_kind = 2'd0;
   endtask

   task automatic test_back_to_back();
      issue_load(5'd16, 32'h0000_5000, 3'b010);
      dmem_rsp_valid = 1'b1; dmem_rsp_rdata = 32'hCAFE_F00D; dmem_rsp_err = 1'b0;
      in_valid = 1'b1; in_kind = 2'd1; in_rd_addr = 5'd17; in_result = 32'h0000_0077;
      n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL b2b_wait_ready: got %b required 0", in_ready); end
      cyc();
      dmem_rsp_valid = 1'b0;
      n_cmp++; if ({rd_write_enable, rd_addr, rd_data, in_ready} !== {1'b1, 5'd16, 32'hCAFE_F00D, 1'b1}) begin n_bad++; $display("FAIL b2b_load: got we=%b rd=%0d data=%h ready=%b required 1 16 cafef00d 1", rd_write_enable, rd_addr, rd_data, in_ready); end
      cyc();
      in_valid = 1'b0; in_kind = 2'd0;
      n_cmp++; if ({rd_write_enable, retire, rd_addr, rd_data} !== {2'b11, 5'd17, 32'h77}) begin n_bad++; $display("FAIL b2b_alu: got we=%b ret=%b rd=%0d data=%h required 1 1 17 00000077", rd_write_enable, retire, rd_addr, rd_data); end
   endtask

   task automatic test_reset_mid_load();
      issue_load(5'd18, 32'h0000_6000, 3'b010);
      repeat (2) cyc();
      rst_n = 1'b0;
      #1;
      n_cmp++; if ({rd_write_enable, retire, load_fault, busy, in_ready} !== 5'b0) begin n_bad++; $display("FAIL midrst_ctl: got %b required 00000", {rd_write_enable, retire, load_fault, busy, in_ready}); end
      n_cmp++; if ({rd_addr, rd_data, fault_addr} !== 69'd0) begin n_bad++; $display("FAIL midrst_data: got %h/%h/%h required 0", rd_addr, rd_data, fault_addr); end
      repeat (2) cyc();
      rst_n = 1'b1;
      cyc();
      respond(32'h9999_9999, 1'b0);
      n_cmp++; if ({rd_write_enable, retire, load_fault, busy, rd_data} !== {4'b0000, 32'h0}) begin n_bad++; $display("FAIL midrst_late: got we/ret/flt/busy=%b data=%h required 0000 00000000", {rd_write_enable, retire, load_fault, busy}, rd_data); end
   endtask

   initial begin
      rst_n = 1'b0;
      in_valid = 1'b0; in_kind = 2'd0; in_rd_addr = '0; in_result = '0; in_funct3 = '0;
      dmem_rsp_valid = 1'b0; dmem_rsp_rdata = '0; dmem_rsp_err = 1'b0;
      repeat (3) cyc();
      test_reset();
      test_alu_back_to_back();
      test_lb_sign();
      test_load_sizes();
      test_bus_error();
      test_timeout();
      test_rd_zero_and_none();
      test_back_to_back();
      test_reset_mid_load();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
